// File: rtl/mips_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one radix-2 step per cycle, magnitude datapath
// with sign fix-up in a final cycle, plus MTHI/MTLO and flush/stall handling.
//
// state | meaning
// IDLE  | waiting; accepts mul/div start or MTHI/MTLO
// RUN   | one shift-add / shift-subtract step per cycle
// FIX   | sign correction, HI/LO write, done pulse
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_x,
  input  logic [2:0]       op_x,
  input  logic [WIDTH-1:0] src_a_x,
  input  logic [WIDTH-1:0] src_b_x,
  input  logic             flush_x,
  input  logic             hilo_use_d,
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int DW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [DW-1:0]    mul_next;
  logic [DW-1:0]    div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_ok;
  logic [DW-1:0]    div_next;
  logic [2*WIDTH-1:0] prod_mag, prod_res;
  logic [WIDTH-1:0] quot_res, rem_res;

  assign signed_op = ~op_x[0];
  assign a_neg     = signed_op & src_a_x[WIDTH-1];
  assign b_neg     = signed_op & src_b_x[WIDTH-1];
  assign a_mag     = a_neg ? (~src_a_x + 1'b1) : src_a_x;
  assign b_mag     = b_neg ? (~src_b_x + 1'b1) : src_b_x;

  // Multiply: {carry, partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = acc_q[DW-1:WIDTH] + {1'b0, opd_q};
  assign mul_next = acc_q[0] ? ({mul_sum, acc_q[WIDTH-1:0]} >> 1) : (acc_q >> 1);

  // Divide: partial remainder in the upper half, quotient bits enter at the bottom.
  assign div_shift = {acc_q[DW-2:0], 1'b0};
  assign div_trial = div_shift[DW-1:WIDTH] - {1'b0, opd_q};
  assign div_ok    = div_shift[DW-1:WIDTH] >= {1'b0, opd_q};
  assign div_next  = div_ok ? {div_trial, div_shift[WIDTH-1:1], 1'b1} : div_shift;

  assign prod_mag = acc_q[2*WIDTH-1:0];
  assign prod_res = neg_q ? (~prod_mag + 1'b1) : prod_mag;
  assign quot_res = div0_q ? '1 : (neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0]);
  assign rem_res  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opd_d     = opd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_x && !flush_x) begin
          if (!op_x[2]) begin
            is_div_d  = op_x[1];
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            div0_d    = op_x[1] && (src_b_x == '0);
            acc_d     = {{(WIDTH+1){1'b0}}, (op_x[1] ? a_mag : b_mag)};
            opd_d     = op_x[1] ? b_mag : a_mag;
            cnt_d     = CW'(WIDTH);
            state_d   = RUN;
          end else if (op_x[2:1] == 2'b10) begin
            if (op_x[0]) lo_d = src_a_x;
            else         hi_d = src_a_x;
          end
        end
      end
      RUN: begin
        if (flush_x) begin
          state_d = IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush_x) begin
          if (is_div_q) begin
            hi_d = rem_res;
            lo_d = quot_res;
          end else begin
            hi_d = prod_res[2*WIDTH-1:WIDTH];
            lo_d = prod_res[WIDTH-1:0];
          end
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opd_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opd_q     <= opd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign stall_req = busy & hilo_use_d;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed and random checks of mips_muldiv_unit at WIDTH=32 and WIDTH=8 against an
// arithmetic reference model of HI/LO.
module tb_mips_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        start32, flush32, use32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        busy32, done32, stall32;

  logic        start8, flush8, use8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8, stall8;

  mips_muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start_x(start32), .op_x(op32),
    .src_a_x(a32), .src_b_x(b32), .flush_x(flush32), .hilo_use_d(use32),
    .busy(busy32), .done(done32), .stall_req(stall32), .hi(hi32), .lo(lo32));

  mips_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start_x(start8), .op_x(op8),
    .src_a_x(a8), .src_b_x(b8), .flush_x(flush8), .hilo_use_d(use8),
    .busy(busy8), .done(done8), .stall_req(stall8), .hi(hi8), .lo(lo8));

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] mhi32 = '0, mlo32 = '0, mhi8 = '0, mlo8 = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_op(input int w, input logic [2:0] op, input logic [63:0] a,
                                 input logic [63:0] b, output logic [63:0] rhi,
                                 output logic [63:0] rlo);
    logic [63:0] mask, ua, ub, p;
    longint sa, sb, sq, sr;
    mask = (64'd1 << w) - 64'd1;
    ua = a & mask;
    ub = b & mask;
    sa = $signed(ua << (64 - w)) >>> (64 - w);
    sb = $signed(ub << (64 - w)) >>> (64 - w);
    rhi = '0;
    rlo = '0;
    case (op)
      3'd0, 3'd1: begin
        p   = (op == 3'd0) ? 64'(sa * sb) : ua * ub;
        rlo = p & mask;
        rhi = (p >> w) & mask;
      end
      default: begin
        if (ub == 0) begin
          rlo = mask;
          rhi = ua;
        end else if (op == 3'd2) begin
          sq  = sa / sb;
          sr  = sa % sb;
          rlo = 64'(sq) & mask;
          rhi = 64'(sr) & mask;
        end else begin
          rlo = (ua / ub) & mask;
          rhi = (ua % ub) & mask;
        end
      end
    endcase
  endfunction

  task automatic drive_start(input bit w8, input logic [2:0] op, input logic [63:0] a,
                             input logic [63:0] b);
    if (w8) begin
      start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = 1'b1; op32 = op; a32 = a[31:0]; b32 = b[31:0];
    end
  endtask

  task automatic release_start;
    start8  = 1'b0;
    start32 = 1'b0;
  endtask

  task automatic check_hilo(input bit w8, input string tag);
    check($sformatf("%s/hi", tag), w8 ? 64'(hi8) : 64'(hi32), w8 ? mhi8 : mhi32);
    check($sformatf("%s/lo", tag), w8 ? 64'(lo8) : 64'(lo32), w8 ? mlo8 : mlo32);
  endtask

  task automatic do_op(input bit w8, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input string tag);
    logic [63:0] rh, rl;
    int lat, w;
    w = w8 ? 8 : 32;
    check($sformatf("%s/idle_before", tag), w8 ? 64'(busy8) : 64'(busy32), 64'd0);
    drive_start(w8, op, a, b);
    tick;
    release_start;
    check($sformatf("%s/busy", tag), w8 ? 64'(busy8) : 64'(busy32), 64'd1);
    lat = -1;
    for (int k = 1; k <= w + 8; k++) begin
      tick;
      if (w8 ? done8 : done32) begin
        lat = k;
        break;
      end
    end
    ref_op(w, op, a, b, rh, rl);
    if (w8) begin mhi8 = rh; mlo8 = rl; end
    else    begin mhi32 = rh; mlo32 = rl; end
    check($sformatf("%s/latency", tag), 64'(lat), 64'(w + 1));
    check_hilo(w8, tag);
    tick;
    check($sformatf("%s/done_pulse", tag), w8 ? 64'(done8) : 64'(done32), 64'd0);
  endtask

  task automatic do_mt(input bit w8, input logic [2:0] op, input logic [63:0] a,
                       input string tag);
    logic [63:0] v;
    v = w8 ? (a & 64'hFF) : (a & 64'hFFFF_FFFF);
    drive_start(w8, op, a, 64'd0);
    tick;
    release_start;
    if (w8) begin if (op[0]) mlo8 = v; else mhi8 = v; end
    else    begin if (op[0]) mlo32 = v; else mhi32 = v; end
    check_hilo(w8, tag);
    check($sformatf("%s/busy", tag), w8 ? 64'(busy8) : 64'(busy32), 64'd0);
    check($sformatf("%s/done", tag), w8 ? 64'(done8) : 64'(done32), 64'd0);
  endtask

  task automatic reset_mid_op(input bit w8, input string tag);
    drive_start(w8, 3'd1, 64'h0000_0000_DEAD_BEEF, 64'h0000_0000_1234_5677);
    tick;
    release_start;
    repeat (4) tick;
    check($sformatf("%s/busy_pre", tag), w8 ? 64'(busy8) : 64'(busy32), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    mhi32 = '0; mlo32 = '0; mhi8 = '0; mlo8 = '0;
    check_hilo(w8, tag);
    check($sformatf("%s/busy", tag), w8 ? 64'(busy8) : 64'(busy32), 64'd0);
    check($sformatf("%s/done", tag), w8 ? 64'(done8) : 64'(done32), 64'd0);
    tick;
    reset = 1'b1;
    repeat (3) tick;
    check($sformatf("%s/no_done", tag), w8 ? 64'(done8) : 64'(done32), 64'd0);
  endtask

  initial begin
    logic [63:0] ra, rb, rh, rl;
    logic [2:0]  rop;
    int scnt;
    bit stall_at_done;

    reset = 1'b0;
    start32 = 1'b0; flush32 = 1'b0; use32 = 1'b1; op32 = '0; a32 = '0; b32 = '0;
    start8  = 1'b0; flush8  = 1'b0; use8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
    #2;
    check("reset/hi", 64'(hi32), 64'd0);
    check("reset/lo", 64'(lo32), 64'd0);
    check("reset/busy", 64'(busy32), 64'd0);
    check("reset/done", 64'(done32), 64'd0);
    check("reset/stall", 64'(stall32), 64'd0);
    use32 = 1'b0;
    tick;
    reset = 1'b1;
    tick;

    do_op(0, 3'd0, 64'hFFFF_FFFF, 64'h2, "mult_neg1x2");
    do_op(0, 3'd1, 64'hFFFF_FFFF, 64'h2, "multu_max2");
    do_op(0, 3'd2, 64'hFFFF_FFF9, 64'h2, "div_m7by2");
    do_op(0, 3'd3, 64'h1234, 64'h0, "divu_by0");
    do_op(0, 3'd2, 64'h8000_0000, 64'hFFFF_FFFF, "div_minbym1");
    do_op(0, 3'd2, 64'hFFFF_FFF9, 64'h0, "div_neg_by0");

    // flush during RUN
    drive_start(0, 3'd2, 64'd100, 64'd7);
    tick;
    release_start;
    repeat (9) tick;
    flush32 = 1'b1;
    tick;
    flush32 = 1'b0;
    check("flush_run/busy", 64'(busy32), 64'd0);
    check("flush_run/done", 64'(done32), 64'd0);
    check_hilo(0, "flush_run");
    repeat (3) tick;
    check("flush_run/no_done", 64'(done32), 64'd0);
    do_mt(0, 3'd5, 64'hA5A5_A5A5, "mtlo");
    do_mt(0, 3'd4, 64'h5A5A_0F0F, "mthi");

    // flush during FIX
    drive_start(0, 3'd0, 64'd3, 64'd5);
    tick;
    release_start;
    repeat (32) tick;
    check("flush_fix/busy_pre", 64'(busy32), 64'd1);
    flush32 = 1'b1;
    tick;
    flush32 = 1'b0;
    check("flush_fix/busy", 64'(busy32), 64'd0);
    check("flush_fix/done", 64'(done32), 64'd0);
    check_hilo(0, "flush_fix");

    // flush together with start in IDLE
    flush32 = 1'b1;
    drive_start(0, 3'd4, 64'h1111_2222, 64'd0);
    tick;
    drive_start(0, 3'd3, 64'd50, 64'd3);
    tick;
    release_start;
    flush32 = 1'b0;
    check("flush_same/busy", 64'(busy32), 64'd0);
    check_hilo(0, "flush_same");

    // 11x no-ops
    drive_start(0, 3'd6, 64'hCAFE_0000, 64'd9);
    tick;
    drive_start(0, 3'd7, 64'hCAFE_0001, 64'd9);
    tick;
    release_start;
    check("noop/busy", 64'(busy32), 64'd0);
    check_hilo(0, "noop");

    // stall_req while a decode instruction wants HI/LO
    use32 = 1'b1;
    drive_start(0, 3'd0, 64'd3, 64'hFFFF_FFFB);
    tick;
    release_start;
    scnt = 0;
    stall_at_done = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (done32) begin
        stall_at_done = stall32;
        break;
      end
      if (stall32) scnt++;
      tick;
    end
    use32 = 1'b0;
    ref_op(32, 3'd0, 64'd3, 64'hFFFF_FFFB, rh, rl);
    mhi32 = rh; mlo32 = rl;
    check("stall/cycles", 64'(scnt), 64'd33);
    check("stall/at_done", 64'(stall_at_done), 64'd0);
    check("stall/done_seen", 64'(done32), 64'd1);
    check_hilo(0, "stall");
    tick;

    reset_mid_op(0, "rst32");
    do_op(0, 3'd1, 64'h0000_0000_DEAD_BEEF, 64'h0000_0000_1234_5677, "rst32_after");

    do_op(1, 3'd0, 64'hFF, 64'h02, "w8_mult");
    reset_mid_op(1, "rst8");
    do_op(1, 3'd2, 64'h80, 64'hFF, "w8_div_minbym1");
    do_op(1, 3'd3, 64'h5A, 64'h00, "w8_divu_by0");
    do_mt(1, 3'd4, 64'h3C, "w8_mthi");

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = 64'($urandom);
      rb  = 64'($urandom);
      if (i % 8 == 0) rb = 64'd0;
      if (i % 8 == 4) begin ra = 64'h80; rb = 64'hFF; end
      do_op(1, rop, ra, rb, $sformatf("w8_rand%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = 64'($urandom);
      rb  = 64'($urandom);
      if (i == 5) rb = 64'd0;
      do_op(0, rop, ra, rb, $sformatf("w32_rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
MIPS_MULDIV_UNIT -- requirements
Module: mips_muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, meaning operand/HI/LO width; legal range 4..64; the counter is $clog2(WIDTH)+1 bits wide.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start_x  input  1  execute-stage request, qualified by op_x.
REQ-005 op_x  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
REQ-006 src_a_x  input  WIDTH  rs operand (multiplicand/dividend/MT source).
REQ-007 src_b_x  input  WIDTH  rt operand (multiplier/divisor).
REQ-008 flush_x  input  1  cancel the in-flight or same-cycle operation.
REQ-009 hilo_use_d  input  1  decode-stage instruction reads HI/LO or is a mul/div/MT op.
REQ-010 busy  output  1  high while in RUN or FIX.
REQ-011 done  output  1  one-cycle pulse on the cycle HI/LO take a mul/div result.
REQ-012 stall_req  output  1  busy AND hilo_use_d (combinational), to the hazard logic.
REQ-013 hi  output  WIDTH  HI register; lo  output  WIDTH  LO register (register outputs, read by MFHI/MFLO).

Function
REQ-014 FSM states are IDLE, RUN and FIX only.
REQ-015 IDLE: start_x with op 000-011 and flush_x low latches operands, sets counter = WIDTH, and goes to RUN.
REQ-016 Signed ops (MULT, DIV) convert operands to magnitudes at latch time and record result sign(s).
REQ-017 RUN: exactly one radix-2 step per cycle (shift-add for mul, restoring shift-subtract for div); counter decrements; at counter==1 the FSM goes to FIX.
REQ-018 FIX: applies sign correction (product negated if signs differ; quotient negated if signs differ; remainder takes the dividend sign), writes HI/LO, pulses done, and returns to IDLE.
REQ-019 Latency: a start accepted at edge N gives HI/LO updated and done high after edge N+WIDTH+1 (33 cycles for WIDTH=32).
REQ-020 Mul result: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2*WIDTH-bit product.
REQ-021 Div result: LO = quotient truncated toward zero, HI = remainder.
REQ-022 Divide by zero: LO = all ones, HI = dividend, completes with normal latency.
REQ-023 Signed DIV of most-negative by -1: LO = most-negative, HI = 0.
REQ-024 MTHI/MTLO in IDLE write src_a_x to HI/LO at the next edge: no busy, no done.
REQ-025 start_x while busy is ignored; hazard logic keeps this from happening, and the bench flags it as an error.
REQ-026 flush_x high in RUN or FIX: return to IDLE at the next edge, HI/LO unchanged, no done pulse.
REQ-027 flush_x high together with start_x in IDLE: the request is discarded, including MTHI/MTLO.
REQ-028 Op codes 11x perform no action.
REQ-029 Internal datapath is 2*WIDTH+1 bits; no intermediate value may be truncated.

Reset
REQ-030 reset low forces at once: state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, all operand/sign registers 0.
REQ-031 reset asserted mid-operation aborts it with no done pulse; after release the first start behaves as from power-up.

Verification
REQ-032 MULT 0xFFFFFFFF x 0x00000002 (WIDTH=32) -> 33 cycles later done=1, HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-033 MULTU 0xFFFFFFFF x 0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE; DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 DIVU 0x00001234 / 0 -> LO=0xFFFFFFFF, HI=0x00001234; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 DIV started, flush_x at cycle 10 -> busy low next cycle, no done, HI/LO keep prior values; then MTLO 0xA5A5A5A5 -> LO=0xA5A5A5A5 after 1 edge.
REQ-036 hilo_use_d held high during MULT -> stall_req high for exactly 33 cycles, low on the cycle done pulses.
REQ-037 reset pulsed low at cycle 5 of a MULTU -> hi=lo=0, busy=0 immediately; repeat with WIDTH=8 and check results against a reference model on random operands.
